mac_stream_accum: RTL

Sequential controller that drives the combinational floating-point FMA (`out = a*b + c`) as a streaming dot-product accumulator. It accepts `(a, b)` operand pairs over a valid/ready handshake and feeds the FMA's `c` input from its own accumulator register, so that `acc = a_i*b_i + acc` on every accepted beat. On the last beat it presents the result on a valid/ready output port. It sits directly upstream and downstream of the FMA: it drives the FMA's `a`, `b` and `c` ports and registers the FMA's `out`.

---
 rtl/mac_stream_accum.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mac_stream_accum.sv
// mac_stream_accum: streaming dot-product controller around an external FMA.
// Define MAC_STREAM_PIPE_EN to register the FMA operands (1 beat / 2 cycles).
module mac_stream_accum #(
  parameter int E_WIDTH = 5,
  parameter int M_WIDTH = 10,
  parameter int I_WIDTH = M_WIDTH + E_WIDTH + 1,
  parameter int LEN_W   = 8,
  parameter int MAX_LEN = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [I_WIDTH-1:0] in_a,
  input  logic [I_WIDTH-1:0] in_b,
  input  logic               in_last,
  input  logic [I_WIDTH-1:0] bias,
  output logic [I_WIDTH-1:0] fma_a,
  output logic [I_WIDTH-1:0] fma_b,
  output logic [I_WIDTH-1:0] fma_c,
  input  logic [I_WIDTH-1:0] fma_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [I_WIDTH-1:0] out_data,
  output logic [LEN_W-1:0]   out_count,
  output logic               out_trunc
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    WAIT,
    OUT
  } state_t;

  localparam logic [LEN_W-1:0] MAX_C = LEN_W'(MAX_LEN);

  state_t             state;
  logic [I_WIDTH-1:0] acc;
  logic [LEN_W-1:0]   cnt;
  logic [LEN_W-1:0]   cnt_nx;
  logic               trunc;
  logic               rdy;
  logic               vld;
  logic               accept;
  logic               done;
  logic [I_WIDTH-1:0] c_sel;

  assign accept = in_valid & rdy;
  assign cnt_nx = cnt + LEN_W'(1);
  // The first beat of a vector seeds c with bias; later beats chain acc.
  assign c_sel  = (state == IDLE) ? bias : acc;

  assign in_ready  = rdy;
  assign out_valid = vld;
  assign out_data  = acc;
  assign out_count = cnt;
  assign out_trunc = trunc;

`ifdef MAC_STREAM_PIPE_EN
  logic [I_WIDTH-1:0] op_a;
  logic [I_WIDTH-1:0] op_b;
  logic [I_WIDTH-1:0] op_c;
  logic               last_q;

  // Capture the FMA operands on accept; the FMA evaluates in WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a   <= '0;
      op_b   <= '0;
      op_c   <= '0;
      last_q <= 1'b0;
    end else if (accept) begin
      op_a   <= in_a;
      op_b   <= in_b;
      op_c   <= c_sel;
      last_q <= in_last;
    end
  end

  assign fma_a = op_a;
  assign fma_b = op_b;
  assign fma_c = op_c;
  // cnt already counts the beat in flight when WAIT evaluates this.
  assign done  = last_q | (cnt == MAX_C);
`else
  assign fma_a = in_a;
  assign fma_b = in_b;
  assign fma_c = c_sel;
  assign done  = in_last | (cnt_nx == MAX_C);
`endif

  // Beat sequencing, accumulation and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      trunc <= 1'b0;
      rdy   <= 1'b1;
      vld   <= 1'b0;
    end else begin
      unique case (state)
        IDLE, ACC: begin
          if (accept) begin
            cnt <= cnt_nx;
`ifdef MAC_STREAM_PIPE_EN
            state <= WAIT;
            rdy   <= 1'b0;
`else
            acc <= fma_out;
            if (done) begin
              state <= OUT;
              trunc <= ~in_last;
              rdy   <= 1'b0;
              vld   <= 1'b1;
            end else begin
              state <= ACC;
            end
`endif
          end
        end
`ifdef MAC_STREAM_PIPE_EN
        WAIT: begin
          acc <= fma_out;
          if (done) begin
            state <= OUT;
            trunc <= ~last_q;
            vld   <= 1'b1;
          end else begin
            state <= ACC;
            rdy   <= 1'b1;
          end
        end
`endif
        OUT: begin
          if (out_ready) begin
            state <= IDLE;
            cnt   <= '0;
            trunc <= 1'b0;
            rdy   <= 1'b1;
            vld   <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
